// File: rtl/hs4_tx_if.sv
// Producer-side valid/ready bus plus the four-phase req/ack bundle of hs4_tx.
// The slave modport is the transmitter's view; master is the surrounding logic.
interface hs4_tx_if #(
    parameter int WIDTH = 3
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             req_out;
    logic             ack_in;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic [7:0]       sent_cnt;

    modport slave (
        input  in_valid, in_data, ack_in,
        output in_ready, req_out, data_out, busy, sent_cnt
    );

    modport master (
        output in_valid, in_data, ack_in,
        input  in_ready, req_out, data_out, busy, sent_cnt
    );
endinterface

// File: rtl/hs4_tx.sv
// Clocked four-phase bundled-data transmitter: a small FIFO fed by valid/ready,
// drained one word per return-to-zero req/ack handshake with a synchronised ack.
module hs4_tx #(
    parameter int WIDTH       = 3,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    hs4_tx_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        REQ_HI,
        REQ_LO
    } state_t;

    state_t               state;
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [WIDTH-1:0]     mem [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q;
    logic                 req_q;
    logic [WIDTH-1:0]     data_q;
    logic [7:0]           cnt_q;
    logic                 ack_s;
    logic                 empty;
    logic                 full;
    logic                 push;
    logic                 pop;

    // The extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = bus.in_valid && !full;
    assign ack_s = sync_q[SYNC_STAGES-1];
    assign pop   = !empty && !ack_s && (state == IDLE || state == REQ_LO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            // NOTE: non-blocking assignments make every stage sample the old value of its neighbour, giving a true shift chain.
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ack_in};
        end
    end

    // NOTE: the storage array has no reset; only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            req_q  <= 1'b0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        data_q <= mem[rd_ptr[AW-1:0]];
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    req_q <= 1'b1;
                    state <= REQ_HI;
                end
                REQ_HI: begin
                    if (ack_s) begin
                        req_q <= 1'b0;
                        state <= REQ_LO;
                    end
                end
                REQ_LO: begin
                    // Handshake has fully returned to zero only once ack_s is low.
                    if (!ack_s) begin
                        cnt_q <= cnt_q + 8'd1;
                        if (pop) begin
                            data_q <= mem[rd_ptr[AW-1:0]];
                            state  <= SETUP;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = !full;
    assign bus.req_out  = req_q;
    assign bus.data_out = data_q;
    assign bus.sent_cnt = cnt_q;
    assign bus.busy     = !empty || (state != IDLE);
endmodule
